// File: rtl/ifetch_queue.sv
// Fetch front end: owns the fetch PC, issues one outstanding memory read at a time,
// and buffers fetched words with their PCs in a first-word-fall-through queue.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   word_q [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  assign full = (count_q == (PW+1)'(DEPTH));
  assign push = (state_q == REQ) && mem_ack && !redirect;
  assign pop  = instr_valid && instr_ready;

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign count       = count_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? word_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_q[rd_ptr_q]   : '0;

  // A request is never withdrawn once issued; a redirect during it only
  // marks the returning word for discard (DROP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      if (redirect) begin
        fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      end
      unique case (state_q)
        IDLE: begin
          if (!redirect && !full) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
            if (!redirect) begin
              fetch_pc_q <= fetch_pc_q + 32'd4;
            end
          end else if (redirect) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        word_q[i] <= '0;
      end
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr_q]   <= mem_addr_q;
        word_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: cycle-level vector table, scoreboard of fetched
// words, and directed sequences for redirect, backpressure, wrap and reset.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  count;

  logic        rst2_n;
  logic        mem_req2;
  logic [31:0] mem_addr2;
  logic [31:0] mem_rdata2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic [2:0]  count2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [2:0]  exp_cnt;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  ent_t        sb[$];
  logic [31:0] acked[$];
  bit          drop;
  bit          pend;
  logic [31:0] pend_addr;

  function automatic logic [31:0] mdata(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign mem_rdata  = mdata(mem_addr);
  assign mem_rdata2 = mdata(mem_addr2);

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .count(count)
  );

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst2_n),
    .redirect(1'b0), .redirect_pc(32'h0),
    .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_req2), .mem_rdata(mem_rdata2),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_ready(1'b1), .count(count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", nm);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    mem_ack     = 1'b0;
    sb.delete();
    acked.delete();
    drop = 0;
    pend = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge: check outputs against the model, drive inputs,
  // advance the model to what the next posedge must produce.
  task automatic cycle(input logic rdr, input logic [31:0] rpc,
                       input logic ack, input logic rdy);
    if (pend) begin
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr", mem_addr, pend_addr);
    end
    chk("count", 32'(count), 32'(sb.size()));
    chk("valid", 32'(instr_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("instr_pc", instr_pc, sb[0].pc);
      chk("instr", instr, sb[0].word);
    end else begin
      chk("instr_zero", instr, 32'h0);
      chk("instr_pc_zero", instr_pc, 32'h0);
    end
    redirect    = rdr;
    redirect_pc = rpc;
    instr_ready = rdy;
    mem_ack     = ack & mem_req;
    if (rdr) begin
      sb.delete();
    end else if (rdy && sb.size() != 0) begin
      void'(sb.pop_front());
    end
    if (mem_req && mem_ack) begin
      if (!rdr && !drop) sb.push_back('{pc: mem_addr, word: mdata(mem_addr)});
      acked.push_back(mem_addr);
      drop = 0;
    end else if (mem_req && rdr) begin
      drop = 1;
    end
    pend      = mem_req && !mem_ack;
    pend_addr = mem_addr;
    @(negedge clk);
  endtask

  vec_t        tbl[9];
  logic [31:0] wrap_addr[$];
  logic [31:0] wrap_pc[$];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h0, 3'd0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0, 3'd1, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h4, 3'd0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h4, 3'd1, 1'b1, 32'h4};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h8, 3'd0, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h8, 3'd1, 1'b1, 32'h8};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'hC, 3'd0, 1'b0, 32'h0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 32'hC, 3'd1, 1'b1, 32'hC};

    rst2_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Zero-wait streaming with a consumer always ready
    foreach (tbl[i]) begin
      chk($sformatf("t%0d_req", i), 32'(mem_req), 32'(tbl[i].exp_req));
      chk($sformatf("t%0d_addr", i), mem_addr, tbl[i].exp_addr);
      chk($sformatf("t%0d_cnt", i), 32'(count), 32'(tbl[i].exp_cnt));
      chk($sformatf("t%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_v));
      chk($sformatf("t%0d_pc", i), instr_pc, tbl[i].exp_pc);
      cycle(1'b0, 32'h0, tbl[i].ack, tbl[i].rdy);
    end

    // Backpressure fills the queue, then one pop reopens fetch
    do_reset();
    repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("full_cnt", 32'(count), 32'd4);
    chk("full_noreq", 32'(mem_req), 32'd0);
    chk("full_acks", 32'(acked.size()), 32'd4);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("pop_cnt", 32'(count), 32'd3);
    chk("pop_noreq", 32'(mem_req), 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("reopen_req", 32'(mem_req), 32'd1);
    chk("reopen_addr", mem_addr, 32'h10);

    // Redirect in IDLE with three entries queued
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("pre_redir_cnt", 32'(count), 32'd3);
    chk("pre_redir_idle", 32'(mem_req), 32'd0);
    cycle(1'b1, 32'h0000_0103, 1'b0, 1'b0);
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_noreq", 32'(mem_req), 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("redir_req", 32'(mem_req), 32'd1);
    chk("redir_addr", mem_addr, 32'h100);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("redir_first_pc", instr_pc, 32'h100);

    // Redirect while a request is stalled: the late word is dropped
    do_reset();
    for (int i = 0; i < 20 && !(mem_req && mem_addr == 32'h8); i++)
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
    if (!(mem_req && mem_addr == 32'h8)) fail_to("reach_req8");
    cycle(1'b1, 32'h200, 1'b0, 1'b1);
    chk("drop_addr1", mem_addr, 32'h8);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drop_addr2", mem_addr, 32'h8);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drop_addr3", mem_addr, 32'h8);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("drop_noreq", 32'(mem_req), 32'd0);
    chk("drop_empty", 32'(instr_valid), 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drop_new_req", 32'(mem_req), 32'd1);
    chk("drop_new_addr", mem_addr, 32'h200);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);

    // Simultaneous push and pop at count=2
    do_reset();
    for (int i = 0; i < 20 && count != 3'd2; i++)
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    if (count != 3'd2) fail_to("reach_cnt2");
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pp_req", 32'(mem_req), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("pp_cnt", 32'(count), 32'd2);
    chk("pp_head", instr_pc, 32'h4);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a request
    do_reset();
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_pc", instr_pc, 32'h0);
    do_reset();

    // Fetch PC wraps modulo 2^32
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 0; i < 20 && wrap_addr.size() < 3; i++) begin
      @(negedge clk);
      if (mem_req2) wrap_addr.push_back(mem_addr2);
      if (instr_valid2) wrap_pc.push_back(instr_pc2);
    end
    if (wrap_addr.size() < 3) begin
      fail_to("wrap_fetch");
    end else begin
      chk("wrap_a0", wrap_addr[0], 32'hFFFF_FFF8);
      chk("wrap_a1", wrap_addr[1], 32'hFFFF_FFFC);
      chk("wrap_a2", wrap_addr[2], 32'h0000_0000);
    end
    if (wrap_pc.size() < 2) begin
      fail_to("wrap_valid");
    end else begin
      chk("wrap_p0", wrap_pc[0], 32'hFFFF_FFF8);
      chk("wrap_p1", wrap_pc[1], 32'hFFFF_FFFC);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
